systolic_feeder: RTL and testbench

Operand-staging and skew stage that sits directly upstream of the 2x2 systolic PE array. It buffers two rows of matrix A and two columns of matrix B, each of length K, loaded through a simple write port. On `start` it clears the array, then streams the operands as diagonally skewed wavefronts onto the array's west and north edges while holding the array's start enable. It signals `done` once the last partial product has reached PE(1,1).

---
 rtl/systolic_pkg.sv | 16 +
 rtl/operand_bank.sv | 41 ++++
 rtl/systolic_feeder.sv | 106 ++++++++++
 tb/tb_systolic_feeder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand feeder: FSM encoding,
// write-port matrix selectors and the default operand width.
package systolic_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic WR_MAT_A = 1'b0;
  localparam logic WR_MAT_B = 1'b1;

  localparam int DEFAULT_WIDTH = 16;
endpackage

// File: rtl/operand_bank.sv
// Two-lane x K-entry operand store. Lane 0 is read at step t and lane 1 at
// step t-1, which gives the one-step diagonal skew into the array.
module operand_bank
  import systolic_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int K     = 4,
  localparam int IW    = $clog2(K),
  localparam int CW    = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic             lane_i,
  input  logic [IW-1:0]    idx_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [CW-1:0]    t_i,
  output logic [WIDTH-1:0] rd0_o,
  output logic [WIDTH-1:0] rd1_o
);
  localparam logic [CW-1:0] KT = CW'(K);

  logic [WIDTH-1:0] mem_q [0:1][0:K-1];
  logic [IW-1:0]    idx0, idx1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < 2; l++)
        for (int i = 0; i < K; i++)
          mem_q[l][i] <= '0;
    end else if (we_i) begin
      mem_q[lane_i][idx_i] <= data_i;
    end
  end

  // Out-of-range steps read as zero so the wavefront edges are padded.
  assign idx0  = IW'(t_i);
  assign idx1  = IW'(t_i - CW'(1));
  assign rd0_o = (t_i < KT)  ? mem_q[0][idx0] : '0;
  assign rd1_o = (t_i != '0) ? mem_q[1][idx1] : '0;
endmodule

// File: rtl/systolic_feeder.sv
// Operand staging and skew feeder for a 2x2 systolic array: clears the array,
// streams skewed A rows west and B columns north, then drains and pulses done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int K     = 4,
  localparam int IW    = $clog2(K),
  localparam int CW    = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic             wr_mat_i,
  input  logic             wr_lane_i,
  input  logic [IW-1:0]    wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pe_clear_o,
  output logic             pe_start_o,
  output logic [WIDTH-1:0] west0_o,
  output logic [WIDTH-1:0] west1_o,
  output logic [WIDTH-1:0] north0_o,
  output logic [WIDTH-1:0] north1_o
);
  localparam logic [CW-1:0] KT = CW'(K);
  localparam logic [IW:0]   KI = (IW + 1)'(K);

  state_e           state_q, state_d;
  logic [CW-1:0]    t_q, t_d;
  logic             wr_ok, a_we, b_we, stream;
  logic [WIDTH-1:0] a_rd0, a_rd1, b_rd0, b_rd1;

  // Operands are frozen for the whole run; late or out-of-range writes vanish.
  assign wr_ok = wr_en_i && !busy_o && ({1'b0, wr_idx_i} < KI);
  assign a_we  = wr_ok && (wr_mat_i == WR_MAT_A);
  assign b_we  = wr_ok && (wr_mat_i == WR_MAT_B);

  operand_bank #(.WIDTH(WIDTH), .K(K)) u_bank_a (
    .clk(clk), .reset(reset), .we_i(a_we), .lane_i(wr_lane_i), .idx_i(wr_idx_i),
    .data_i(wr_data_i), .t_i(t_q), .rd0_o(a_rd0), .rd1_o(a_rd1)
  );

  operand_bank #(.WIDTH(WIDTH), .K(K)) u_bank_b (
    .clk(clk), .reset(reset), .we_i(b_we), .lane_i(wr_lane_i), .idx_i(wr_idx_i),
    .data_i(wr_data_i), .t_i(t_q), .rd0_o(b_rd0), .rd1_o(b_rd1)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    pe_clear_o = 1'b0;
    pe_start_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy_o     = 1'b1;
        pe_clear_o = 1'b1;
        t_d        = '0;
        state_d    = ST_STREAM;
      end
      ST_STREAM: begin
        busy_o     = 1'b1;
        pe_start_o = 1'b1;
        if (t_q == KT) begin
          t_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        busy_o     = 1'b1;
        pe_start_o = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stream   = (state_q == ST_STREAM);
  assign west0_o  = stream ? a_rd0 : '0;
  assign west1_o  = stream ? a_rd1 : '0;
  assign north0_o = stream ? b_rd0 : '0;
  assign north1_o = stream ? b_rd1 : '0;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: a K=2 instance with a behavioural 2x2
// array attached, and a K=4 instance for index boundary and back-to-back runs.
module tb_systolic_feeder;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // K=2 instance
  logic reset, wr_en, wr_mat, wr_lane, start;
  logic [0:0] wr_idx;
  logic [W-1:0] wr_data;
  logic busy, done, pe_clear, pe_start;
  logic [W-1:0] w0, w1, n0, n1;

  // K=4 instance
  logic reset4, wr_en4, wr_mat4, wr_lane4, start4;
  logic [1:0] wr_idx4;
  logic [W-1:0] wr_data4;
  logic busy4, done4, pe_clear4, pe_start4;
  logic [W-1:0] w04, w14, n04, n14;

  systolic_feeder #(.WIDTH(W), .K(2)) dut (
    .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_mat_i(wr_mat), .wr_lane_i(wr_lane),
    .wr_idx_i(wr_idx), .wr_data_i(wr_data), .start_i(start), .busy_o(busy), .done_o(done),
    .pe_clear_o(pe_clear), .pe_start_o(pe_start), .west0_o(w0), .west1_o(w1),
    .north0_o(n0), .north1_o(n1)
  );

  systolic_feeder #(.WIDTH(W), .K(4)) dut4 (
    .clk(clk), .reset(reset4), .wr_en_i(wr_en4), .wr_mat_i(wr_mat4), .wr_lane_i(wr_lane4),
    .wr_idx_i(wr_idx4), .wr_data_i(wr_data4), .start_i(start4), .busy_o(busy4), .done_o(done4),
    .pe_clear_o(pe_clear4), .pe_start_o(pe_start4), .west0_o(w04), .west1_o(w14),
    .north0_o(n04), .north1_o(n14)
  );

  wire [4*W-1:0] ops = {w0, w1, n0, n1};
  wire [3:0]     flg = {pe_clear, busy, pe_start, done};

  // Behavioural 2x2 output-stationary array fed by the K=2 instance
  logic [W-1:0] wq00, nq00, wq10, nq01;
  logic [31:0]  acc [4];
  always @(posedge clk) begin
    if (pe_clear) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      wq00 <= '0; nq00 <= '0; wq10 <= '0; nq01 <= '0;
    end else if (pe_start) begin
      acc[0] <= acc[0] + w0 * n0;
      acc[1] <= acc[1] + wq00 * n1;
      acc[2] <= acc[2] + w1 * nq00;
      acc[3] <= acc[3] + wq10 * nq01;
      wq00 <= w0; nq00 <= n0; wq10 <= w1; nq01 <= n1;
    end
  end

  task automatic wr2(input logic m, input logic l, input logic [0:0] i, input logic [W-1:0] d);
    @(negedge clk); wr_en = 1; wr_mat = m; wr_lane = l; wr_idx = i; wr_data = d;
    @(negedge clk); wr_en = 0;
  endtask

  task automatic wr4(input logic m, input logic l, input logic [1:0] i, input logic [W-1:0] d);
    @(negedge clk); wr_en4 = 1; wr_mat4 = m; wr_lane4 = l; wr_idx4 = i; wr_data4 = d;
    @(negedge clk); wr_en4 = 0;
  endtask

  // Returns at the negedge inside the CLEAR cycle
  task automatic kick();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic kick4();
    @(negedge clk); start4 = 1;
    @(negedge clk); start4 = 0;
  endtask

  task automatic load_k2();
    wr2(0, 0, 0, 16'd1); wr2(0, 0, 1, 16'd2);
    wr2(0, 1, 0, 16'd3); wr2(0, 1, 1, 16'd4);
    wr2(1, 0, 0, 16'd5); wr2(1, 0, 1, 16'd7);
    wr2(1, 1, 0, 16'd6); wr2(1, 1, 1, 16'd8);
  endtask

  task automatic test_reset();
    reset = 0; reset4 = 0;
    repeat (2) @(negedge clk);
    checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flg); end
    checks++; if (ops !== '0) begin errors++; $display("FAIL reset_ops: got %h want 0", ops); end
    checks++; if ({pe_clear4, busy4, pe_start4, done4} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags4: got %b want 0000", {pe_clear4, busy4, pe_start4, done4}); end
    checks++; if ({w04, w14, n04, n14} !== '0) begin
      errors++; $display("FAIL reset_ops4: got %h want 0", {w04, w14, n04, n14}); end
    reset = 1; reset4 = 1;
  endtask

  task automatic test_stream();
    logic [4*W-1:0] exp_ops [4];
    exp_ops[0] = {16'd1, 16'd0, 16'd5, 16'd0};
    exp_ops[1] = {16'd2, 16'd3, 16'd7, 16'd6};
    exp_ops[2] = {16'd0, 16'd4, 16'd0, 16'd8};
    exp_ops[3] = '0;
    load_k2();
    kick();
    checks++; if (flg !== 4'b1100) begin errors++; $display("FAIL stream_clear: got %b want 1100", flg); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (ops !== exp_ops[c]) begin
        errors++; $display("FAIL stream_ops[%0d]: got %h want %h", c, ops, exp_ops[c]); end
      checks++; if (flg !== 4'b0110) begin
        errors++; $display("FAIL stream_flags[%0d]: got %b want 0110", c, flg); end
    end
    @(negedge clk);
    checks++; if (flg !== 4'b0001) begin errors++; $display("FAIL stream_done: got %b want 0001", flg); end
    checks++; if (acc[0] !== 32'd19) begin errors++; $display("FAIL array_c00: got %0d want 19", acc[0]); end
    checks++; if (acc[1] !== 32'd22) begin errors++; $display("FAIL array_c01: got %0d want 22", acc[1]); end
    checks++; if (acc[2] !== 32'd43) begin errors++; $display("FAIL array_c10: got %0d want 43", acc[2]); end
    checks++; if (acc[3] !== 32'd50) begin errors++; $display("FAIL array_c11: got %0d want 50", acc[3]); end
    @(negedge clk);
    checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL stream_idle: got %b want 0000", flg); end
  endtask

  task automatic test_start_during_stream();
    logic [4*W-1:0] exp_ops [4];
    int ndone;
    exp_ops[0] = {16'd1, 16'd0, 16'd5, 16'd0};
    exp_ops[1] = {16'd2, 16'd3, 16'd7, 16'd6};
    exp_ops[2] = {16'd0, 16'd4, 16'd0, 16'd8};
    exp_ops[3] = '0;
    kick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (ops !== exp_ops[c] || flg !== 4'b0110) begin
        errors++; $display("FAIL restart_step[%0d]: got %h/%b want %h/0110", c, ops, flg, exp_ops[c]); end
      start = (c == 1);
    end
    start = 0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", done); end
    checks++; if (acc[3] !== 32'd50) begin errors++; $display("FAIL restart_c11: got %0d want 50", acc[3]); end
    ndone = 0;
    repeat (8) begin @(negedge clk); if (done || busy) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL restart_extra: got %0d extra active cycles want 0", ndone); end
  endtask

  task automatic test_write_while_busy();
    kick();
    wr_en = 1; wr_mat = 0; wr_lane = 0; wr_idx = 0; wr_data = 16'd9;
    @(negedge clk); wr_en = 0;
    checks++; if (w0 !== 16'd1) begin errors++; $display("FAIL busy_wr_cur: got %0d want 1", w0); end
    repeat (4) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_wr_done: got %b want 1", done); end
    kick();
    @(negedge clk);
    checks++; if (w0 !== 16'd1) begin errors++; $display("FAIL busy_wr_next: got %0d want 1", w0); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    kick();
    @(negedge clk);
    @(negedge clk);
    checks++; if (ops !== {16'd2, 16'd3, 16'd7, 16'd6}) begin
      errors++; $display("FAIL midrst_step1: got %h want 0002000300070006", ops); end
    reset = 0;
    @(negedge clk);
    checks++; if (flg !== 4'b0000 || ops !== '0) begin
      errors++; $display("FAIL midrst_after: got %b/%h want 0000/0", flg, ops); end
    reset = 1;
    ndone = 0;
    repeat (8) begin @(negedge clk); if (done) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_nodone: got %0d want 0", ndone); end
    kick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (ops !== '0 || pe_start !== 1'b1) begin
        errors++; $display("FAIL midrst_zero[%0d]: got %h/%b want 0/1", c, ops, pe_start); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_idx_boundary();
    logic [W-1:0] exp_n1;
    for (int i = 0; i < 4; i++) wr4(1, 1, 2'(i), W'(10 + i));
    wr4(0, 1, 2'd3, 16'd77);
    kick4();
    checks++; if (pe_clear4 !== 1'b1) begin errors++; $display("FAIL k4_clear: got %b want 1", pe_clear4); end
    for (int t = 0; t <= 4; t++) begin
      @(negedge clk);
      exp_n1 = (t >= 1) ? W'(9 + t) : '0;
      checks++; if (n14 !== exp_n1 || n04 !== '0) begin
        errors++; $display("FAIL k4_north[%0d]: got %0d/%0d want %0d/0", t, n14, n04, exp_n1); end
    end
    checks++; if (w14 !== 16'd77 || w04 !== '0) begin
      errors++; $display("FAIL k4_west_last: got %0d/%0d want 77/0", w14, w04); end
    @(negedge clk);
    checks++; if (pe_start4 !== 1'b1 || n14 !== '0) begin
      errors++; $display("FAIL k4_drain: got %b/%0d want 1/0", pe_start4, n14); end
    @(negedge clk);
    checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL k4_done: got %b want 1", done4); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_f;
    @(negedge clk); start4 = 1;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      exp_f = {(c % 9 == 1), (c % 9 == 8), !((c % 9 == 8) || (c % 9 == 0))};
      checks++; if ({pe_clear4, done4, busy4} !== exp_f) begin
        errors++; $display("FAIL b2b_cyc[%0d]: got %b want %b", c, {pe_clear4, done4, busy4}, exp_f); end
    end
    start4 = 0;
    repeat (2) @(negedge clk);
    checks++; if ({pe_clear4, done4, busy4} !== 3'b000) begin
      errors++; $display("FAIL b2b_stop: got %b want 000", {pe_clear4, done4, busy4}); end
  endtask

  initial begin
    reset = 0; wr_en = 0; wr_mat = 0; wr_lane = 0; wr_idx = '0; wr_data = '0; start = 0;
    reset4 = 0; wr_en4 = 0; wr_mat4 = 0; wr_lane4 = 0; wr_idx4 = '0; wr_data4 = '0; start4 = 0;
    test_reset();
    test_stream();
    test_start_during_stream();
    test_write_while_busy();
    test_reset_mid_run();
    test_idx_boundary();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
